hb_elastic_fifo: RTL and testbench

- Parametrised single-clock elastic FIFO for the HyperBus read-data path.
- Sits after the clock-domain-crossing stage. Absorbs a bursty, non-throttleable word stream (no backpressure on the write side) and presents a ready/valid stream to the AXI side.
- Withholds output until a configurable prefill level is reached, or until a burst end is already stored, so downstream sees gap-free bursts.
- Adds burst framing, fill-level reporting and sticky overflow/underflow flags.

---
 rtl/hb_elastic_fifo.sv | 77 +++++++
 tb/tb_hb_elastic_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hb_elastic_fifo.sv
// hb_elastic_fifo: single-clock elastic FIFO that prefills before streaming,
// with burst framing, fill level and sticky overflow/underflow flags.
module hb_elastic_fifo #(
   parameter int DATA_WIDTH      = 16,
   parameter int DEPTH_LOG2      = 3,
   parameter int START_THRESHOLD = 2
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  srst,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_vld,
   input  logic                  din_last,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_vld,
   output logic                  dout_last,
   input  logic                  dout_rdy,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full,
   output logic                  ovf,
   output logic                  udf
);
   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;
   generate
      if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 6 || START_THRESHOLD < 1 || START_THRESHOLD > DEPTH) begin : g_bad_param
         $error("hb_elastic_fifo: DEPTH_LOG2 or START_THRESHOLD out of range");
      end
   endgenerate
   typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
   state_t                state, state_nxt;
   logic [DATA_WIDTH:0]   mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0]         level_nxt, last_cnt, last_cnt_nxt;
   logic                  head_last, push, pop, udf_set;
   assign head_last    = mem[rd_ptr][DATA_WIDTH];
   assign dout         = mem[rd_ptr][DATA_WIDTH-1:0];
   assign dout_vld     = state == STREAM && level != '0;
   assign dout_last    = head_last & dout_vld;
   assign full         = level == LW'(DEPTH);
   assign pop          = dout_vld & dout_rdy;
   assign push         = din_vld & (~full | pop);
   assign level_nxt    = level + LW'(push) - LW'(pop);
   assign last_cnt_nxt = last_cnt + LW'(push & din_last) - LW'(pop & head_last);
   // Running dry in STREAM without having delivered a burst end is starvation.
   assign udf_set      = state == STREAM && level_nxt == '0 && !(pop && head_last);
   always_comb begin
      state_nxt = state;
      if (state == STREAM)
         state_nxt = (pop && head_last) ? (level_nxt == '0 ? IDLE : FILL) : STREAM;
      else if (level_nxt >= LW'(START_THRESHOLD) || last_cnt_nxt != '0)
         state_nxt = STREAM;
      else if (level_nxt != '0)
         state_nxt = FILL;
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {din_last, din};
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         last_cnt <= '0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
      end else begin
         state    <= srst ? IDLE : state_nxt;
         wr_ptr   <= srst ? '0 : wr_ptr + DEPTH_LOG2'(push);
         rd_ptr   <= srst ? '0 : rd_ptr + DEPTH_LOG2'(pop);
         level    <= srst ? '0 : level_nxt;
         last_cnt <= srst ? '0 : last_cnt_nxt;
         ovf      <= srst ? 1'b0 : ovf | (din_vld & full & ~pop);
         udf      <= srst ? 1'b0 : udf | udf_set;
      end
   end
endmodule

// File: tb/tb_hb_elastic_fifo.sv
// tb_hb_elastic_fifo: directed stimulus with a scoreboard queue checked by an
// independent output monitor, plus direct checks of level and flags.
module tb_hb_elastic_fifo;
   logic        clk = 1'b0;
   logic        arst_n, srst, din_vld, din_last, dout_rdy;
   logic [15:0] din, dout;
   logic        dout_vld, dout_last, full, ovf, udf;
   logic [3:0]  level;
   logic [16:0] sb [$];
   logic [16:0] exp_w;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   hb_elastic_fifo #(.DATA_WIDTH(16), .DEPTH_LOG2(3), .START_THRESHOLD(2)) dut (
      .clk(clk), .arst_n(arst_n), .srst(srst), .din(din), .din_vld(din_vld),
      .din_last(din_last), .dout(dout), .dout_vld(dout_vld), .dout_last(dout_last),
      .dout_rdy(dout_rdy), .level(level), .full(full), .ovf(ovf), .udf(udf)
   );

   always @(negedge clk) begin
      if (arst_n && dout_vld && dout_rdy) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got last=%0b data=%h, expected no output", dout_last, dout);
         end else begin
            exp_w = sb.pop_front();
            if ({dout_last, dout} !== exp_w) begin
               errors++;
               $display("FAIL output_word: got last=%0b data=%h, expected last=%0b data=%h",
                        dout_last, dout, exp_w[16], exp_w[15:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [15:0] d, input logic l);
      din = d; din_last = l; din_vld = 1'b1;
      sb.push_back({l, d});
   endtask

   task automatic idle();
      din_vld = 1'b0; din_last = 1'b0;
   endtask

   task automatic sync_clear();
      srst = 1'b1;
      step();
      srst = 1'b0;
      sb.delete();
   endtask

   initial begin
      arst_n = 1'b0; srst = 1'b0; din = '0; din_vld = 1'b0; din_last = 1'b0; dout_rdy = 1'b0;
      #12;
      chk("rst_level", 32'(level), 0);
      chk("rst_vld", 32'(dout_vld), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_flags", {30'd0, ovf, udf}, 0);
      arst_n = 1'b1;
      step();

      // Prefill: two words needed before the first one appears
      dout_rdy = 1'b1;
      put(16'h1111, 1'b0);
      chk("pre_vld_c0", 32'(dout_vld), 0);
      step();
      put(16'h2222, 1'b0);
      chk("pre_vld_c1", 32'(dout_vld), 0);
      chk("pre_level_c1", 32'(level), 1);
      step();
      idle();
      chk("pre_vld_c2", 32'(dout_vld), 1);
      chk("pre_dout_c2", 32'(dout), 32'h1111);
      step();
      chk("pre_dout_c3", 32'(dout), 32'h2222);
      step();
      chk("pre_level_end", 32'(level), 0);
      chk("pre_vld_end", 32'(dout_vld), 0);
      chk("pre_udf_starve", 32'(udf), 1);
      sync_clear();
      chk("srst_udf", 32'(udf), 0);

      // Short burst: a stored last word bypasses the threshold
      put(16'hABCD, 1'b1);
      step();
      idle();
      chk("sb_vld", 32'(dout_vld), 1);
      chk("sb_last", 32'(dout_last), 1);
      chk("sb_level", 32'(level), 1);
      step();
      put(16'h5555, 1'b0);
      chk("sb_idle_level", 32'(level), 0);
      chk("sb_idle_udf", 32'(udf), 0);
      step();
      put(16'h6666, 1'b1);
      chk("sb_refill_vld", 32'(dout_vld), 0);
      step();
      idle();
      chk("sb2_vld", 32'(dout_vld), 1);
      chk("sb2_level", 32'(level), 2);
      step();
      chk("sb2_last", 32'(dout_last), 1);
      step();
      chk("sb2_level_end", 32'(level), 0);
      chk("sb2_udf", 32'(udf), 0);

      // Fill to DEPTH with the output stalled
      dout_rdy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         put(16'(i), 1'b0);
         step();
         chk("ovf_fill_level", 32'(level), 32'(i + 1));
      end
      idle();
      chk("full_after_8", 32'(full), 1);
      chk("ovf_after_8", 32'(ovf), 0);

      // Push and pop together while full
      dout_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         put(16'h0100 + 16'(i), 1'b0);
         step();
         chk("fpp_level", 32'(level), 8);
         chk("fpp_ovf", 32'(ovf), 0);
      end
      idle();

      // Ninth word into a full, stalled FIFO is dropped
      dout_rdy = 1'b0;
      din = 16'h0008; din_last = 1'b0; din_vld = 1'b1;
      step();
      idle();
      chk("ovf_set", 32'(ovf), 1);
      chk("ovf_level", 32'(level), 8);
      dout_rdy = 1'b1;
      for (int i = 0; i < 20 && level != 0; i++) step();
      chk("drain_level", 32'(level), 0);
      chk("drain_sb_empty", 32'(sb.size()), 0);
      chk("ovf_sticky", 32'(ovf), 1);

      // srst with level 3 and a simultaneous write
      dout_rdy = 1'b0;
      sync_clear();
      for (int i = 0; i < 3; i++) begin
         put(16'h0C00 + 16'(i), 1'b0);
         step();
      end
      idle();
      chk("srst_pre_level", 32'(level), 3);
      din = 16'h0077; din_vld = 1'b1;
      sync_clear();
      idle();
      chk("srst_level", 32'(level), 0);
      chk("srst_vld", 32'(dout_vld), 0);
      chk("srst_flags", {30'd0, ovf, udf}, 0);
      dout_rdy = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("srst_no_stale", 32'(level), 0);

      // Underflow: starvation mid-burst, then resume without re-prefill
      put(16'h0A01, 1'b0);
      step();
      put(16'h0A02, 1'b0);
      step();
      idle();
      chk("udf_vld_c2", 32'(dout_vld), 1);
      step();
      step();
      chk("udf_set", 32'(udf), 1);
      chk("udf_gap_vld", 32'(dout_vld), 0);
      step();
      chk("udf_gap_vld2", 32'(dout_vld), 0);
      put(16'h0A03, 1'b1);
      step();
      idle();
      chk("udf_resume_vld", 32'(dout_vld), 1);
      chk("udf_resume_last", 32'(dout_last), 1);
      step();
      chk("udf_end_level", 32'(level), 0);
      put(16'h0A04, 1'b0);
      step();
      idle();
      chk("udf_idle_vld", 32'(dout_vld), 0);

      // Asynchronous reset mid-burst with level 5
      dout_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         put(16'h0D00 + 16'(i), 1'b0);
         step();
      end
      idle();
      chk("arst_pre_level", 32'(level), 5);
      #3 arst_n = 1'b0;
      #1;
      sb.delete();
      chk("arst_level", 32'(level), 0);
      chk("arst_vld", 32'(dout_vld), 0);
      chk("arst_full", 32'(full), 0);
      chk("arst_flags", {30'd0, ovf, udf}, 0);
      #2 arst_n = 1'b1;
      dout_rdy = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("arst_no_stale", 32'(dout_vld), 0);
      chk("final_sb_empty", 32'(sb.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
